au_cic_decimator: RTL and testbench



---
 rtl/auCicPkg.sv | 22 ++
 rtl/au_cic_channel.sv | 128 ++++++++++++
 rtl/au_cic_decimator.sv | 143 ++++++++++++++
 tb/tb_au_cic_decimator.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/auCicPkg.sv
// Shared constants, accumulator type and shift clamp helper for the AU CIC decimator.
package auCicPkg;

    localparam int unsigned AU_CIC_ORDER     = 3;
    localparam int unsigned AU_CIC_MAX_SHIFT = 45;
    localparam int unsigned AU_CIC_IN_W      = 18;
    localparam int unsigned AU_CIC_ACC_W     = 63;
    localparam int unsigned AU_CIC_DEC_W     = 15;
    localparam int unsigned AU_CIC_SHIFT_W   = 6;

    typedef logic signed [AU_CIC_ACC_W-1:0] au_cic_acc_t;

    // Shift values beyond the accumulator growth are pinned to the maximum.
    function automatic logic [AU_CIC_SHIFT_W-1:0] au_cic_clamp_shift(
        input logic [AU_CIC_SHIFT_W-1:0] sh
    );
        logic [AU_CIC_SHIFT_W-1:0] lim;
        lim = AU_CIC_SHIFT_W'(AU_CIC_MAX_SHIFT);
        return (sh > lim) ? lim : sh;
    endfunction

endpackage

// File: rtl/au_cic_channel.sv
// One CIC channel: integrator cascade, comb cascade, scale and saturate.
// Optional build macro: AU_CIC_ROUND_EN (round half up before the shift).
module au_cic_channel
    import auCicPkg::*;
#(
    parameter int unsigned IN_W  = AU_CIC_IN_W,
    parameter int unsigned ACC_W = AU_CIC_ACC_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      integ_en,
    input  logic                      comb_en,
    input  logic                      out_en,
    input  logic [AU_CIC_SHIFT_W-1:0] shift,
    input  logic signed [IN_W-1:0]    x,
    output logic signed [IN_W-1:0]    y,
    output logic                      sat_c
);

    localparam int unsigned EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};
    localparam logic signed [IN_W-1:0]  Y_MAX   = {1'b0, {(IN_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0]  Y_MIN   = {1'b1, {(IN_W-1){1'b0}}};

    logic signed [ACC_W-1:0] integ_q [AU_CIC_ORDER];
    logic signed [ACC_W-1:0] integ_d [AU_CIC_ORDER];
    logic signed [ACC_W-1:0] dly_q   [AU_CIC_ORDER];
    logic signed [ACC_W-1:0] dly_d   [AU_CIC_ORDER];
    logic signed [ACC_W-1:0] comb_q;
    logic signed [ACC_W-1:0] comb_d;
    logic signed [IN_W-1:0]  y_q;
    logic signed [IN_W-1:0]  y_d;

    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] integ_acc;
    logic signed [ACC_W-1:0] comb_acc;
    logic signed [EXT_W-1:0] pre_c;
    logic signed [EXT_W-1:0] scaled_c;

    // Integrator cascade; each stage sees the updated value of the previous one, wrapping freely.
    always_comb begin
        x_ext     = {{(ACC_W-IN_W){x[IN_W-1]}}, x};
        integ_acc = x_ext;
        for (int k = 0; k < int'(AU_CIC_ORDER); k++) begin
            integ_d[k] = integ_q[k];
            if (integ_en) begin
                integ_d[k] = integ_q[k] + integ_acc;
            end
            integ_acc = integ_d[k];
        end
        if (clear) begin
            for (int k = 0; k < int'(AU_CIC_ORDER); k++) begin
                integ_d[k] = '0;
            end
        end
    end

    // Comb cascade evaluated on a dump; all three differences land in one register.
    always_comb begin
        comb_acc = integ_q[AU_CIC_ORDER-1];
        comb_d   = comb_q;
        for (int k = 0; k < int'(AU_CIC_ORDER); k++) begin
            dly_d[k] = dly_q[k];
            if (comb_en) begin
                dly_d[k] = comb_acc;
                comb_acc = comb_acc - dly_q[k];
            end
        end
        if (comb_en) begin
            comb_d = comb_acc;
        end
        if (clear) begin
            comb_d = '0;
            for (int k = 0; k < int'(AU_CIC_ORDER); k++) begin
                dly_d[k] = '0;
            end
        end
    end

    // Optional rounding, arithmetic shift and clip to the output range.
    always_comb begin
        pre_c = {comb_q[ACC_W-1], comb_q};
`ifdef AU_CIC_ROUND_EN
        if (shift != '0) begin
            pre_c = pre_c + (EXT_W'(1) << (shift - AU_CIC_SHIFT_W'(1)));
        end
`endif
        scaled_c = pre_c >>> shift;
        sat_c    = (scaled_c > SAT_MAX) || (scaled_c < SAT_MIN);
        y_d      = y_q;
        if (out_en) begin
            if (scaled_c > SAT_MAX) begin
                y_d = Y_MAX;
            end else if (scaled_c < SAT_MIN) begin
                y_d = Y_MIN;
            end else begin
                y_d = scaled_c[IN_W-1:0];
            end
        end
        if (clear) begin
            y_d = '0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(AU_CIC_ORDER); k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
            comb_q <= '0;
            y_q    <= '0;
        end else begin
            for (int k = 0; k < int'(AU_CIC_ORDER); k++) begin
                integ_q[k] <= integ_d[k];
                dly_q[k]   <= dly_d[k];
            end
            comb_q <= comb_d;
            y_q    <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/au_cic_decimator.sv
// Complex third-order CIC decimator feeding the AU resampler.
// Optional build macro: AU_CIC_ROUND_EN (round half up before the shift).
module au_cic_decimator
    import auCicPkg::*;
#(
    parameter int unsigned IN_W  = AU_CIC_IN_W,
    parameter int unsigned ACC_W = AU_CIC_ACC_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clkEn,
    input  logic signed [IN_W-1:0]    iIn,
    input  logic signed [IN_W-1:0]    qIn,
    input  logic                      auEnable,
    input  logic [AU_CIC_DEC_W-1:0]   auDecimation,
    input  logic [AU_CIC_SHIFT_W-1:0] auShift,
    output logic signed [IN_W-1:0]    iOut,
    output logic signed [IN_W-1:0]    qOut,
    output logic                      outValid,
    output logic                      satFlag
);

    logic                      en_q,       en_d;
    logic [AU_CIC_DEC_W-1:0]   cnt_q,      cnt_d;
    logic [AU_CIC_SHIFT_W-1:0] sh_q,       sh_d;
    logic                      dump_q,     dump_d;
    logic [AU_CIC_SHIFT_W-1:0] dump_sh_q,  dump_sh_d;
    logic                      comb_vld_q, comb_vld_d;
    logic [AU_CIC_SHIFT_W-1:0] comb_sh_q,  comb_sh_d;
    logic                      out_vld_q,  out_vld_d;
    logic                      sat_q,      sat_d;

    logic [AU_CIC_DEC_W-1:0]   r_live_c;
    logic [AU_CIC_SHIFT_W-1:0] sh_live_c;
    logic [AU_CIC_DEC_W-1:0]   cnt_cur_c;
    logic [AU_CIC_SHIFT_W-1:0] sh_cur_c;
    logic                      integ_en_c;
    logic                      dump_c;
    logic                      clear_c;
    logic                      sat_i_c;
    logic                      sat_q_c;

    // Period counter, config capture and the dump -> comb -> output valid pipeline.
    // On the first enabled cycle the live registers stand in for the captured values.
    always_comb begin
        r_live_c   = (auDecimation == '0) ? AU_CIC_DEC_W'(1) : auDecimation;
        sh_live_c  = au_cic_clamp_shift(auShift);
        cnt_cur_c  = en_q ? cnt_q : (r_live_c - AU_CIC_DEC_W'(1));
        sh_cur_c   = en_q ? sh_q  : sh_live_c;
        integ_en_c = auEnable && clkEn;
        dump_c     = integ_en_c && (cnt_cur_c == '0);
        clear_c    = !auEnable;

        en_d       = auEnable;
        cnt_d      = cnt_cur_c;
        sh_d       = sh_cur_c;
        dump_d     = dump_c;
        dump_sh_d  = sh_cur_c;
        comb_vld_d = dump_q;
        comb_sh_d  = dump_sh_q;
        out_vld_d  = comb_vld_q;
        sat_d      = comb_vld_q && (sat_i_c || sat_q_c);

        if (integ_en_c) begin
            cnt_d = dump_c ? (r_live_c - AU_CIC_DEC_W'(1)) : (cnt_cur_c - AU_CIC_DEC_W'(1));
        end
        if (dump_c) begin
            sh_d = sh_live_c;
        end
        if (!auEnable) begin
            en_d       = 1'b0;
            cnt_d      = '0;
            sh_d       = '0;
            dump_d     = 1'b0;
            dump_sh_d  = '0;
            comb_vld_d = 1'b0;
            comb_sh_d  = '0;
            out_vld_d  = 1'b0;
            sat_d      = 1'b0;
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= 1'b0;
            cnt_q      <= '0;
            sh_q       <= '0;
            dump_q     <= 1'b0;
            dump_sh_q  <= '0;
            comb_vld_q <= 1'b0;
            comb_sh_q  <= '0;
            out_vld_q  <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            dump_q     <= dump_d;
            dump_sh_q  <= dump_sh_d;
            comb_vld_q <= comb_vld_d;
            comb_sh_q  <= comb_sh_d;
            out_vld_q  <= out_vld_d;
            sat_q      <= sat_d;
        end
    end

    au_cic_channel #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_chan_i (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear_c),
        .integ_en (integ_en_c),
        .comb_en  (dump_q),
        .out_en   (comb_vld_q),
        .shift    (comb_sh_q),
        .x        (iIn),
        .y        (iOut),
        .sat_c    (sat_i_c)
    );

    au_cic_channel #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_chan_q (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear_c),
        .integ_en (integ_en_c),
        .comb_en  (dump_q),
        .out_en   (comb_vld_q),
        .shift    (comb_sh_q),
        .x        (qIn),
        .y        (qOut),
        .sat_c    (sat_q_c)
    );

    assign outValid = out_vld_q;
    assign satFlag  = sat_q;

endmodule

// File: tb/tb_au_cic_decimator.sv
// Bench for au_cic_decimator: directed and randomized steps against a closed-form CIC model.
module tb_au_cic_decimator;

    localparam int unsigned IN_W = 18;
    localparam longint SAT_MAX = 131071;
    localparam longint SAT_MIN = -131072;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   clkEn;
    logic                   auEnable;
    logic signed [IN_W-1:0] iIn;
    logic signed [IN_W-1:0] qIn;
    logic [14:0]            auDecimation;
    logic [5:0]             auShift;
    logic signed [IN_W-1:0] iOut;
    logic signed [IN_W-1:0] qOut;
    logic                   outValid;
    logic                   satFlag;

    always #5 clk = ~clk;

    au_cic_decimator dut (
        .clk          (clk),
        .reset        (reset),
        .clkEn        (clkEn),
        .iIn          (iIn),
        .qIn          (qIn),
        .auEnable     (auEnable),
        .auDecimation (auDecimation),
        .auShift      (auShift),
        .iOut         (iOut),
        .qOut         (qOut),
        .outValid     (outValid),
        .satFlag      (satFlag)
    );

    typedef struct {
        int                     due;
        logic signed [IN_W-1:0] i;
        logic signed [IN_W-1:0] q;
        logic                   sat;
    } exp_t;

    exp_t                   expq[$];
    longint                 hist_i[$];
    longint                 hist_q[$];
    longint                 prev_i[3];
    longint                 prev_q[3];
    bit                     m_active;
    bit                     m_dumped;
    int                     m_r;
    int                     m_sh;
    int                     m_cnt;
    logic signed [IN_W-1:0] last_i;
    logic signed [IN_W-1:0] last_q;
    int                     cyc;
    int                     n_pass;
    int                     n_fail;
    int                     n_total;

    function automatic int r_of(input logic [14:0] d);
        return (d == 15'd0) ? 1 : int'(d);
    endfunction

    function automatic int sh_of(input logic [5:0] s);
        return (s > 6'd45) ? 45 : int'(s);
    endfunction

    // Third integrator output after n samples: sum of x[k] * C(n-1-k+2, 2).
    function automatic longint i3_of(input longint h[$]);
        longint s;
        longint m;
        s = 0;
        for (int k = 0; k < h.size(); k++) begin
            m = longint'(h.size() - 1 - k);
            s += ((m + 1) * (m + 2) / 2) * h[k];
        end
        return s;
    endfunction

    function automatic longint scale(input longint c, input int sh);
        longint v;
        v = c;
`ifdef AU_CIC_ROUND_EN
        if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
`endif
        return v >>> sh;
    endfunction

    function automatic longint clip(input longint v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    task automatic do_dump(input int e);
        longint d_i, d_q, c_i, c_q, s_i, s_q;
        exp_t   ex;
        d_i = i3_of(hist_i);
        d_q = i3_of(hist_q);
        c_i = d_i - 3 * prev_i[0] + 3 * prev_i[1] - prev_i[2];
        c_q = d_q - 3 * prev_q[0] + 3 * prev_q[1] - prev_q[2];
        prev_i[2] = prev_i[1]; prev_i[1] = prev_i[0]; prev_i[0] = d_i;
        prev_q[2] = prev_q[1]; prev_q[1] = prev_q[0]; prev_q[0] = d_q;
        s_i = scale(c_i, m_sh);
        s_q = scale(c_q, m_sh);
        ex.due = e + 2;
        ex.i   = IN_W'(clip(s_i));
        ex.q   = IN_W'(clip(s_q));
        ex.sat = (clip(s_i) != s_i) || (clip(s_q) != s_q);
        expq.push_back(ex);
    endtask

    // Apply one clock edge to the model and the DUT, then check all outputs.
    task automatic tick();
        int   e;
        bit   exp_v;
        logic exp_sat;
        exp_t ex;
        e = cyc + 1;
        m_dumped = 1'b0;
        if (reset || !auEnable) begin
            m_active = 1'b0;
            expq.delete();
            last_i = '0;
            last_q = '0;
        end else begin
            if (!m_active) begin
                m_active = 1'b1;
                m_r   = r_of(auDecimation);
                m_sh  = sh_of(auShift);
                m_cnt = 0;
                hist_i.delete();
                hist_q.delete();
                for (int k = 0; k < 3; k++) begin
                    prev_i[k] = 0;
                    prev_q[k] = 0;
                end
            end
            if (clkEn) begin
                hist_i.push_back(longint'(iIn));
                hist_q.push_back(longint'(qIn));
                m_cnt++;
                if (m_cnt == m_r) begin
                    do_dump(e);
                    m_cnt    = 0;
                    m_r      = r_of(auDecimation);
                    m_sh     = sh_of(auShift);
                    m_dumped = 1'b1;
                end
            end
        end
        @(posedge clk);
        cyc = e;
        @(negedge clk);
        exp_v   = (expq.size() != 0) && (expq[0].due == cyc);
        exp_sat = 1'b0;
        if (exp_v) begin
            ex      = expq.pop_front();
            last_i  = ex.i;
            last_q  = ex.q;
            exp_sat = ex.sat;
        end
        n_total++;
        assert (outValid === exp_v) n_pass++;
        else begin n_fail++; $error("FAIL valid cyc=%0d got=%b exp=%b", cyc, outValid, exp_v); end
        n_total++;
        assert (iOut === last_i) n_pass++;
        else begin n_fail++; $error("FAIL iOut cyc=%0d got=%0d exp=%0d", cyc, iOut, last_i); end
        n_total++;
        assert (qOut === last_q) n_pass++;
        else begin n_fail++; $error("FAIL qOut cyc=%0d got=%0d exp=%0d", cyc, qOut, last_q); end
        n_total++;
        assert (satFlag === exp_sat) n_pass++;
        else begin n_fail++; $error("FAIL satFlag cyc=%0d got=%b exp=%b", cyc, satFlag, exp_sat); end
    endtask

    task automatic wait_dump();
        for (int k = 0; k < 20; k++) begin
            tick();
            if (m_dumped) break;
        end
    endtask

    initial begin
        cyc = 0; n_pass = 0; n_fail = 0; n_total = 0;
        m_active = 1'b0; m_dumped = 1'b0; m_r = 1; m_sh = 0; m_cnt = 0;
        last_i = '0; last_q = '0;
        reset = 1'b1; auEnable = 1'b1; clkEn = 1'b0;
        iIn = '0; qIn = '0; auDecimation = 15'd4; auShift = 6'd6;

        // Reset holds everything at zero even with clkEn activity.
        for (int k = 0; k < 4; k++) begin
            clkEn = 1'($urandom);
            iIn   = IN_W'($urandom);
            tick();
        end

        // Steady state: R=4, shift=6, constant input.
        reset = 1'b0; clkEn = 1'b1; iIn = 18'sd1000; qIn = -18'sd1000;
        repeat (40) tick();
        n_total++;
        assert (iOut === 18'sd1000) n_pass++;
        else begin n_fail++; $error("FAIL steady_i got=%0d exp=1000", iOut); end
        n_total++;
        assert (qOut === -18'sd1000) n_pass++;
        else begin n_fail++; $error("FAIL steady_q got=%0d exp=-1000", qOut); end

        // Impulse: R=2, shift=3.
        auEnable = 1'b0; repeat (2) tick();
        auDecimation = 15'd2; auShift = 6'd3; auEnable = 1'b1;
        iIn = 18'sd8; qIn = '0; tick();
        iIn = '0;
        repeat (12) tick();

        // Saturation: R=4, shift=0, full-scale inputs.
        auEnable = 1'b0; repeat (2) tick();
        auDecimation = 15'd4; auShift = 6'd0; auEnable = 1'b1;
        iIn = 18'sd131071; qIn = -18'sd131072;
        repeat (30) tick();
        n_total++;
        assert (iOut === 18'sd131071) n_pass++;
        else begin n_fail++; $error("FAIL sat_pos got=%0d exp=131071", iOut); end
        n_total++;
        assert (qOut === -18'sd131072) n_pass++;
        else begin n_fail++; $error("FAIL sat_neg got=%0d exp=-131072", qOut); end

        // R=0 acts as R=1: passthrough with 2-clock latency.
        auEnable = 1'b0; repeat (2) tick();
        auDecimation = 15'd0; auShift = 6'd0; auEnable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            iIn = IN_W'($urandom); qIn = IN_W'($urandom);
            tick();
        end

        // Shift 63 is clamped to 45.
        auEnable = 1'b0; repeat (2) tick();
        auDecimation = 15'd4; auShift = 6'd63; auEnable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            iIn = IN_W'($urandom); qIn = IN_W'($urandom);
            tick();
        end

        // Rounding: R=2, shift=4, input 1 gives comb 8.
        auEnable = 1'b0; repeat (2) tick();
        auDecimation = 15'd2; auShift = 6'd4; auEnable = 1'b1;
        iIn = 18'sd1; qIn = -18'sd1;
        repeat (12) tick();
        n_total++;
`ifdef AU_CIC_ROUND_EN
        assert (iOut === 18'sd1) n_pass++;
        else begin n_fail++; $error("FAIL round got=%0d exp=1", iOut); end
`else
        assert (iOut === 18'sd0) n_pass++;
        else begin n_fail++; $error("FAIL trunc got=%0d exp=0", iOut); end
`endif

        // Enable dropped one cycle after a dump discards the pending output.
        auEnable = 1'b0; repeat (2) tick();
        auDecimation = 15'd4; auShift = 6'd2; auEnable = 1'b1;
        iIn = 18'sd300; qIn = -18'sd77;
        repeat (9) tick();
        wait_dump();
        auEnable = 1'b0; repeat (3) tick();

        // Reset asserted one cycle after a dump.
        auEnable = 1'b1;
        repeat (9) tick();
        wait_dump();
        reset = 1'b1; tick();
        reset = 1'b0; repeat (4) tick();

        // Decimation change 4 -> 8 mid-period.
        auEnable = 1'b0; repeat (2) tick();
        auDecimation = 15'd4; auShift = 6'd3; auEnable = 1'b1;
        iIn = 18'sd500; qIn = 18'sd20;
        repeat (2) tick();
        auDecimation = 15'd8;
        repeat (30) tick();

        // Randomized traffic with config churn and occasional disruptions.
        for (int k = 0; k < 300; k++) begin
            clkEn = 1'($urandom);
            iIn   = IN_W'($urandom);
            qIn   = IN_W'($urandom);
            if ($urandom_range(0, 15) == 0) auDecimation = 15'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) auShift = 6'($urandom_range(0, 12));
            auEnable = ($urandom_range(0, 40) != 0);
            reset    = ($urandom_range(0, 60) == 0);
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
